// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: takes packed stereo samples {left[31:16], right[15:0]}
// over a valid/ready handshake and shifts them out to the codec DAC.
// AUD_BCLK and AUD_DACLRCK are derived from AUDIO_CLK.
//
// Ports:
//   AUDIO_CLK     master audio clock (rising edge)
//   rst           asynchronous active-low reset
//   sample_in     {left[15:0], right[15:0]}, two's complement
//   sample_valid  sample_in is valid
//   sample_ready  holding buffer empty; transfer on valid & ready
//   AUD_BCLK      codec bit clock, AUDIO_CLK / (2*BCLK_DIV)
//   AUD_DACLRCK   frame clock, 1 = left slot, 0 = right slot
//   AUD_DACDAT    serial data, MSB first, changes on BCLK falling edge
//   underrun      one-cycle pulse when a frame starts with no sample
//   underrun_cnt  saturating underrun count
//
// Build option: define DAC_I2S_MODE_EN for Philips I2S timing. In that mode
// AUD_DACDAT lags AUD_DACLRCK by one BCLK. Without the macro the output is
// left-justified.
module audio_dac_serializer #(
  parameter int unsigned BCLK_DIV  = 6,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned UCNT_W    = 8
) (
  input  logic              AUDIO_CLK,
  input  logic              rst,
  input  logic [31:0]       sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int unsigned FRAME_W = 2 * SLOT_BITS;
  localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               lrck_q, lrck_d;
  logic               dat_q, dat_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [31:0]        buf_q, buf_d;
  logic               ready_q, ready_d;
  logic               underrun_q, underrun_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;
`ifdef DAC_I2S_MODE_EN
  logic               dly_q, dly_d;
`endif

  logic fall_c;
  logic load_c;
  logic xfer_c;

  // Slot layout: left, zero pad, right, zero pad.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [31:0] s);
    logic [FRAME_W-1:0] l;
    logic [FRAME_W-1:0] r;
    l = FRAME_W'(s[31:16]) << (FRAME_W - 16);
    r = FRAME_W'(s[15:0]) << (SLOT_BITS - 16);
    return l | r;
  endfunction

  // Event decode: BCLK falling edge, and the fall that wraps the frame.
  always_comb begin
    fall_c = bclk_q && (div_cnt_q == DIV_LAST);
    load_c = fall_c && (bit_cnt_q == BIT_LAST);
    xfer_c = sample_valid && ready_q;
  end

  // Next-state logic for the divider, bit counter, buffer and shifter.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dat_d      = dat_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    ready_d    = ready_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
`ifdef DAC_I2S_MODE_EN
    dly_d      = dly_q;
`endif

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (fall_c) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      lrck_d    = (bit_cnt_d < SLOT_LEN);
    end

    if (load_c) begin
      if (!ready_q) begin
        // Held sample goes out; buffer frees up.
        shift_d = pack_frame(buf_q);
        ready_d = 1'b1;
      end else if (xfer_c) begin
        // Sample arriving on the load cycle bypasses the buffer.
        shift_d = pack_frame(sample_in);
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
        if (ucnt_q != '1) begin
          ucnt_d = ucnt_q + UCNT_W'(1);
        end
      end
    end else begin
      if (fall_c) begin
        shift_d = shift_q << 1;
      end
      if (xfer_c) begin
        buf_d   = sample_in;
        ready_d = 1'b0;
      end
    end

    // Serial bit only moves on BCLK falls so it is stable on BCLK rises.
    if (fall_c) begin
`ifdef DAC_I2S_MODE_EN
      dly_d = shift_d[FRAME_W-1];
      dat_d = dly_q;
`else
      dat_d = shift_d[FRAME_W-1];
`endif
    end
  end

  // State registers.
  always_ff @(posedge AUDIO_CLK or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      shift_q    <= '0;
      buf_q      <= '0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
`ifdef DAC_I2S_MODE_EN
      dly_q      <= 1'b0;
`endif
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
`ifdef DAC_I2S_MODE_EN
      dly_q      <= dly_d;
`endif
    end
  end

  assign sample_ready = ready_q;
  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer (BCLK_DIV=2, SLOT_BITS=16, UCNT_W=2).
// Expected frames are queued as stimulus is applied; a bit monitor rebuilds
// frames from the serial pins and they are compared in order.
module tb_audio_dac_serializer;

  localparam int BCLK_DIV  = 2;
  localparam int SLOT_BITS = 16;
  localparam int UCNT_W    = 2;
  localparam int FRAME_W   = 2 * SLOT_BITS;
  localparam int BIT_EDGES = 2 * BCLK_DIV;
  localparam int FRAME_EDGES = FRAME_W * BIT_EDGES;

  logic              AUDIO_CLK = 1'b0;
  logic              rst;
  logic [31:0]       sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              AUD_BCLK;
  logic              AUD_DACLRCK;
  logic              AUD_DACDAT;
  logic              underrun;
  logic [UCNT_W-1:0] underrun_cnt;

  always #5 AUDIO_CLK = ~AUDIO_CLK;

  audio_dac_serializer #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS),
    .UCNT_W   (UCNT_W)
  ) dut (
    .AUDIO_CLK   (AUDIO_CLK),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int n_pushed = 0;
  int rd = 0;
  logic [31:0] exp_q[$];

  // Frame monitor: samples DACDAT on each BCLK rise, aligned to LRCK rising.
  logic [31:0] got_mem [0:63];
  int          got_wr = 0;
  logic        mon_bclk = 1'b0;
  logic        mon_lr = 1'b0;
  logic [31:0] mon_word = '0;
  int          mon_cnt = 0;
`ifdef DAC_I2S_MODE_EN
  logic        mon_pend = 1'b0;
`endif

  always @(negedge AUDIO_CLK) begin
    logic lr_edge;
    logic active;
    if (!rst) begin
      mon_bclk = 1'b0;
      mon_lr   = 1'b0;
      mon_cnt  = 0;
`ifdef DAC_I2S_MODE_EN
      mon_pend = 1'b0;
`endif
    end else begin
      if (AUD_BCLK && !mon_bclk) begin
        lr_edge = AUD_DACLRCK && !mon_lr;
`ifdef DAC_I2S_MODE_EN
        active   = (mon_cnt != 0) || mon_pend;
        mon_pend = lr_edge;
`else
        active = (mon_cnt != 0) || lr_edge;
`endif
        if (active) begin
          mon_word = {mon_word[30:0], AUD_DACDAT};
          mon_cnt  = mon_cnt + 1;
          if (mon_cnt == FRAME_W) begin
            if (got_wr < 64) got_mem[got_wr] = mon_word;
            got_wr  = got_wr + 1;
            mon_cnt = 0;
          end
        end
        mon_lr = AUD_DACLRCK;
      end
      mon_bclk = AUD_BCLK;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int load_edge(input int k);
    return BIT_EDGES + k * FRAME_EDGES;
  endfunction

  // One AUDIO_CLK cycle; checks BCLK/LRCK against the divider model.
  task automatic step();
    int   bc;
    logic lr_e;
    @(posedge AUDIO_CLK);
    edge_n++;
    @(negedge AUDIO_CLK);
    bc   = (edge_n >= BIT_EDGES) ? ((edge_n - BIT_EDGES) / BIT_EDGES) % FRAME_W : 0;
    lr_e = (edge_n >= BIT_EDGES) && (bc < SLOT_BITS);
    check($sformatf("bclk@%0d", edge_n), 32'(AUD_BCLK), 32'((edge_n / BCLK_DIV) % 2));
    check($sformatf("lrck@%0d", edge_n), 32'(AUD_DACLRCK), 32'(lr_e));
  endtask

  task automatic goto(input int k);
    while (edge_n < k) step();
  endtask

  task automatic expect_frame(input logic [31:0] f);
    exp_q.push_back(f);
    n_pushed++;
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    check({tag, "_frame_count"}, 32'(got_wr), 32'(n_pushed));
    while (rd < got_wr && rd < 64 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("frame%0d", rd), got_mem[rd], e);
      rd++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bclk"},  32'(AUD_BCLK), 32'd0);
    check({tag, "_lrck"},  32'(AUD_DACLRCK), 32'd0);
    check({tag, "_dat"},   32'(AUD_DACDAT), 32'd0);
    check({tag, "_ready"}, 32'(sample_ready), 32'd1);
    check({tag, "_urun"},  32'(underrun), 32'd0);
    check({tag, "_ucnt"},  32'(underrun_cnt), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge AUDIO_CLK);
    check_reset_vals("rst0");
    rst    = 1'b1;
    edge_n = 0;

    // Sample written into the buffer before the first frame load.
    sample_valid = 1'b1;
    sample_in    = 32'hA5C3_0F0F;
    step();
    sample_valid = 1'b0;
    expect_frame(32'hA5C3_0F0F);
    check("ready_after_write", 32'(sample_ready), 32'd0);
    goto(load_edge(0));
    check("load0_urun", 32'(underrun), 32'd0);
    check("load0_ready", 32'(sample_ready), 32'd1);
    check("load0_ucnt", 32'(underrun_cnt), 32'd0);

    // Three starved frames.
    for (int k = 1; k <= 3; k++) begin
      goto(load_edge(k));
      expect_frame(32'h0);
      check($sformatf("urun_pulse%0d", k), 32'(underrun), 32'd1);
      check($sformatf("ucnt%0d", k), 32'(underrun_cnt), 32'(k));
      step();
      check($sformatf("urun_end%0d", k), 32'(underrun), 32'd0);
    end

    // Bypass: valid presented exactly on the load edge with an empty buffer.
    goto(load_edge(4) - 1);
    sample_valid = 1'b1;
    sample_in    = 32'hDEAD_BEEF;
    step();
    sample_valid = 1'b0;
    expect_frame(32'hDEAD_BEEF);
    check("bypass_urun", 32'(underrun), 32'd0);
    check("bypass_ready", 32'(sample_ready), 32'd1);
    check("bypass_ucnt", 32'(underrun_cnt), 32'd3);

    // Two more underruns: counter saturates at 3.
    for (int k = 5; k <= 6; k++) begin
      goto(load_edge(k));
      expect_frame(32'h0);
      check($sformatf("sat_urun%0d", k), 32'(underrun), 32'd1);
      check($sformatf("sat_ucnt%0d", k), 32'(underrun_cnt), 32'd3);
    end

    // Back-to-back samples with valid held high.
    goto(load_edge(6) + 28 - 1);
    sample_valid = 1'b1;
    sample_in    = 32'h1111_2222;
    step();
    sample_in = 32'h3333_4444;
    expect_frame(32'h1111_2222);
    check("b2b_ready_low", 32'(sample_ready), 32'd0);
    goto(load_edge(7) - 1);
    check("b2b_ready_hold", 32'(sample_ready), 32'd0);
    step();
    check("b2b_load_ready", 32'(sample_ready), 32'd1);
    check("b2b_load_urun", 32'(underrun), 32'd0);
    step();
    check("b2b_second_xfer", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    expect_frame(32'h3333_4444);
    goto(load_edge(8) - 1);
    check("b2b_ready_hold2", 32'(sample_ready), 32'd0);
    step();
    check("b2b_load2_ready", 32'(sample_ready), 32'd1);
    check("b2b_load2_urun", 32'(underrun), 32'd0);

    goto(load_edge(9));
    check("f9_urun", 32'(underrun), 32'd1);
    check("f9_ucnt", 32'(underrun_cnt), 32'd3);

    // Fill the buffer in the right slot, then reset mid-slot.
    goto(load_edge(9) + 68 - 1);
    sample_valid = 1'b1;
    sample_in    = 32'hCAFE_F00D;
    step();
    sample_valid = 1'b0;
    check("mid_ready_low", 32'(sample_ready), 32'd0);
    goto(load_edge(9) + 84);
    drain("epoch1");

    rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge AUDIO_CLK);
    rst    = 1'b1;
    edge_n = 0;

    // Held sample discarded: first frame after reset underruns.
    goto(load_edge(0));
    expect_frame(32'h0);
    check("post_rst_urun", 32'(underrun), 32'd1);
    check("post_rst_ucnt", 32'(underrun_cnt), 32'd1);
    check("post_rst_ready", 32'(sample_ready), 32'd1);
    goto(load_edge(1) + 60);
    drain("epoch2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
Downstream stage of the echo filter. Accepts a packed stereo sample {left[31:16], right[15:0]} through a valid/ready handshake and serialises it to the codec DAC. The block generates the codec bit clock (AUD_BCLK) and the DAC frame clock (AUD_DACLRCK) by dividing AUDIO_CLK. AUD_DACLRCK is also the strobe the echo filter uses to capture its history sample.

Parameters:
BCLK_DIV, 6, AUDIO_CLK cycles per BCLK half-period (BCLK = AUDIO_CLK/(2*BCLK_DIV)); legal values ≥1.
SLOT_BITS, 16, BCLK cycles per channel slot; must be ≥16; bits after the 16 data bits are zero-padded.
UCNT_W, 8, width of the saturating underrun counter.

Ports:
AUDIO_CLK  in  1  master audio clock; all logic on rising edge
rst  in  1  asynchronous active-low reset
sample_in  in  32  {left[15:0], right[15:0]}, two's complement
sample_valid  in  1  sample_in is valid
sample_ready  out  1  holding buffer empty; transfer occurs when valid & ready
AUD_BCLK  out  1  codec bit clock
AUD_DACLRCK  out  1  frame clock: 1 = left slot, 0 = right slot
AUD_DACDAT  out  1  serial data, MSB first, changes on BCLK falling edge
underrun  out  1  one-cycle pulse when a frame starts with no sample available
underrun_cnt  out  UCNT_W  saturating count of underruns

Behaviour:
Reset is asynchronous, active-low, and applies on rst==0. Reset values:
- AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, sample_ready=1, underrun=0, underrun_cnt=0.
- div_cnt=0, bit_cnt=2*SLOT_BITS-1, shift register=0, holding buffer empty.

Clock divider:
- div_cnt counts 0..BCLK_DIV-1. When div_cnt==BCLK_DIV-1, div_cnt returns to 0 and AUD_BCLK toggles.
- A "fall event" is the AUDIO_CLK edge on which AUD_BCLK toggles 1→0.

Bit counter:
- bit_cnt counts 0..2*SLOT_BITS-1 and advances only on fall events. It wraps from 2*SLOT_BITS-1 to 0.
- AUD_DACLRCK is registered and updated on the fall event. Its value is 1 when the new bit_cnt < SLOT_BITS, else 0.
- Frame length is 2*SLOT_BITS BCLKs. Default is 32 BCLK = 384 AUDIO_CLK cycles.

Frame load:
- A frame load happens on the fall event where bit_cnt wraps to 0. The first fall event after reset is a frame load.
- Shift register layout: left[15:0], then SLOT_BITS-16 zeros, then right[15:0], then SLOT_BITS-16 zeros.
- Loading: if the holding buffer is full, its contents load into the shift register and the buffer empties, so sample_ready=1 on the next cycle.
- If the buffer is empty and valid&ready is high in the same cycle, the incoming sample loads directly into the shift register (bypass). This is not an underrun, and the buffer stays empty.
- Otherwise all zeros load, underrun pulses for 1 cycle, and underrun_cnt increments, saturating at all-ones.

Handshake and shifting:
- valid&ready outside a load cycle writes the holding buffer. sample_ready goes 0 on the next cycle and stays 0 until the next frame load.
- On every non-load fall event the shift register shifts left by one. AUD_DACDAT = shift register MSB, registered, so data changes only on fall events and is stable across each BCLK rising edge.
- Latency: an accepted sample starts appearing on AUD_DACDAT at the next frame load, at most one frame plus one cycle later.

Reset mid-frame: all state returns to reset values, and any held sample is discarded.

Optional Feature:
Macro: DAC_I2S_MODE_EN
- Defined: Philips I2S timing. AUD_DACDAT lags AUD_DACLRCK by one BCLK. The bit driven on the LRCK-edge fall event is the last bit of the previous slot, and the MSB follows on the next fall event. This is implemented with one extra delay flop on DACDAT, updated on fall events.
- Undefined: left-justified timing. The MSB is driven on the same fall event as the LRCK edge.
- Clocks, handshake and underrun behaviour are identical in both modes.

Test Plan:
1. Reset, BCLK_DIV=2, SLOT_BITS=16, free run → AUD_BCLK period 4 AUDIO_CLK cycles; LRCK period 128 cycles, high 64 / low 64; all outputs at reset values while rst=0.
2. Push 32'hA5C3_0F0F before the first frame load → left slot shifts out 1010010111000011 MSB first, right slot shifts out 0000111100001111; no underrun.
3. No sample supplied for 3 frames → DACDAT all 0; underrun pulses 3 times, one per frame load; underrun_cnt=3; with UCNT_W=2 and 5 underruns, underrun_cnt saturates at 3.
4. Buffer empty and sample_valid asserted exactly on the frame-load cycle → sample transmitted in that frame (bypass); no underrun; sample_ready stays 1.
5. Back-to-back samples with sample_valid held high → exactly one transfer per frame, sample_ready low between transfer and load; frame sequence 0x1111_2222, 0x3333_4444 output in order with no repeats or drops.
6. rst asserted mid-right-slot with the buffer full → outputs return to reset values immediately; after release the held sample is not transmitted and the first frame underruns. Additionally, with DAC_I2S_MODE_EN defined, rerun case 2 → the MSB appears one BCLK after the LRCK edge.
